// File: rtl/fc_layer_seq_pkg.sv
// Shared types and fixed-point helpers for fc_layer_seq (package fc_pkg).
// FC_SEQ_SATURATE_EN selects saturating arithmetic; default is two's-complement wrap.
package fc_pkg;

  // Helpers work on a 64-bit container, so the callers' WIDTH must be <= 64.
  localparam int MAXW = 64;

  typedef logic signed [MAXW-1:0]   wide_t;
  typedef logic signed [2*MAXW-1:0] dbl_t;

`ifdef FC_SEQ_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, FWD, BWD_SCALE, BWD, DONE} state_t;

  // Squeeze an exact value into a w-bit signed word: clamp or wrap.
  function automatic wide_t fx_fit(input dbl_t v, input int w);
    dbl_t hi, lo, t;
    hi = (dbl_t'(1) <<< (w - 1)) - dbl_t'(1);
    lo = -hi - dbl_t'(1);
    if (SAT_EN) begin
      if (v > hi)      t = hi;
      else if (v < lo) t = lo;
      else             t = v;
    end else begin
      t = (v <<< (2*MAXW - w)) >>> (2*MAXW - w);
    end
    return wide_t'(t);
  endfunction

  function automatic wide_t fx_mul(input wide_t a, input wide_t b, input int w, input int f);
    dbl_t p;
    p = dbl_t'(a) * dbl_t'(b);
    return fx_fit(p >>> f, w);
  endfunction

  function automatic wide_t fx_add(input wide_t a, input wide_t b, input int w);
    return fx_fit(dbl_t'(a) + dbl_t'(b), w);
  endfunction

endpackage

// File: rtl/fc_layer_seq_mac_lane.sv
// One output column's multiply-accumulate: prod = a*b (fixed point), sum = acc + prod.
// Saturation follows FC_SEQ_SATURATE_EN through fc_pkg.
module fc_mac_lane
  import fc_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic signed [WIDTH-1:0] mul_a,
  input  logic signed [WIDTH-1:0] mul_b,
  input  logic signed [WIDTH-1:0] acc_in,
  output logic signed [WIDTH-1:0] prod,
  output logic signed [WIDTH-1:0] sum
);

  always_comb begin
    prod = WIDTH'(fx_mul(wide_t'(mul_a), wide_t'(mul_b), WIDTH, FRAC_BITS));
    sum  = WIDTH'(fx_add(wide_t'(acc_in), wide_t'(prod), WIDTH));
  end

endmodule

// File: rtl/fc_layer_seq.sv
// Sequential fully connected layer: forward y = W*[1;x], backward input error + weight update.
// Optional macro FC_SEQ_SATURATE_EN enables saturating multiply/add.
module fc_layer_seq
  import fc_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int FRAC_BITS  = 16,
  parameter int INPUT_DIM  = 4,
  parameter int OUTPUT_DIM = 4,
  parameter logic signed [WIDTH-1:0] LEARNING_RATE = WIDTH'(32'sh0000_1000),
  localparam int RW = $clog2(INPUT_DIM + 1),
  localparam int CW = (OUTPUT_DIM > 1) ? $clog2(OUTPUT_DIM) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_mode,
  input  logic [WIDTH*INPUT_DIM-1:0]  in_data,
  input  logic [WIDTH*OUTPUT_DIM-1:0] in_error,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_mode,
  output logic [WIDTH*OUTPUT_DIM-1:0] out_data,
  output logic [WIDTH*INPUT_DIM-1:0]  out_error,
  input  logic                        w_wr_en,
  input  logic [RW-1:0]               w_wr_row,
  input  logic [CW-1:0]               w_wr_col,
  input  logic [WIDTH-1:0]            w_wr_data,
  input  logic [RW-1:0]               w_rd_row,
  input  logic [CW-1:0]               w_rd_col,
  output logic [WIDTH-1:0]            w_rd_data
);

  localparam int NROW = INPUT_DIM + 1;
  localparam int CNTW = $clog2(INPUT_DIM + 2);

  typedef logic signed [WIDTH-1:0] word_t;

  localparam logic [CNTW-1:0] LAST_ROW = CNTW'(INPUT_DIM);
  localparam logic [CNTW-1:0] FIN_ROW  = CNTW'(INPUT_DIM + 1);
  localparam word_t           ONE      = word_t'(64'd1 << FRAC_BITS);

  state_t          state_q, state_d;
  logic [CNTW-1:0] row;

  word_t w_mem   [NROW][OUTPUT_DIM];
  word_t x_reg   [INPUT_DIM];
  word_t eacc    [INPUT_DIM];
  word_t err_reg [OUTPUT_DIM];
  word_t g_reg   [OUTPUT_DIM];
  word_t acc     [OUTPUT_DIM];
  word_t wrow    [OUTPUT_DIM];
  word_t la [OUTPUT_DIM], lb [OUTPUT_DIM], lc [OUTPUT_DIM];
  word_t lp [OUTPUT_DIM], ls [OUTPUT_DIM];
  word_t x_cur, esum;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = in_mode ? BWD_SCALE : FWD;
      end
      FWD:       if (row == FIN_ROW) state_d = DONE;
      BWD_SCALE: state_d = BWD;
      BWD:       if (row == FIN_ROW) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  // Current weight row and x element; the extra finishing row reads zeros.
  always_comb begin
    x_cur = '0;
    for (int unsigned k = 0; k < INPUT_DIM; k++)
      if (32'(row) == k + 1) x_cur = x_reg[k];
    for (int unsigned c = 0; c < OUTPUT_DIM; c++) begin
      wrow[c] = '0;
      for (int unsigned r = 0; r < NROW; r++)
        if (32'(row) == r) wrow[c] = w_mem[r][c];
    end
  end

  always_comb begin
    wide_t s;
    s = '0;
    for (int unsigned c = 0; c < OUTPUT_DIM; c++)
      s = fx_add(s, fx_mul(wide_t'(err_reg[c]), wide_t'(wrow[c]), WIDTH, FRAC_BITS), WIDTH);
    esum = WIDTH'(s);
  end

  // Lanes are shared: forward MAC, gradient scaling, bias add (g*1.0) and weight update.
  always_comb begin
    for (int unsigned c = 0; c < OUTPUT_DIM; c++) begin
      la[c] = x_cur;
      lb[c] = wrow[c];
      lc[c] = acc[c];
      if (state_q == BWD_SCALE) begin
        la[c] = LEARNING_RATE;
        lb[c] = err_reg[c];
      end else if (state_q == BWD) begin
        la[c] = (row == '0) ? g_reg[c] : x_cur;
        lb[c] = (row == '0) ? ONE : g_reg[c];
        lc[c] = wrow[c];
      end
    end
  end

  for (genvar gi = 0; gi < OUTPUT_DIM; gi++) begin : g_lane
    fc_mac_lane #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) u_lane (
      .mul_a (la[gi]),
      .mul_b (lb[gi]),
      .acc_in(lc[gi]),
      .prod  (lp[gi]),
      .sum   (ls[gi])
    );
  end

  always_comb begin
    w_rd_data = '0;
    for (int unsigned r = 0; r < NROW; r++)
      for (int unsigned c = 0; c < OUTPUT_DIM; c++)
        if (32'(w_rd_row) == r && 32'(w_rd_col) == c) w_rd_data = w_mem[r][c];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row       <= '0;
      out_mode  <= 1'b0;
      out_data  <= '0;
      out_error <= '0;
      for (int unsigned r = 0; r < NROW; r++)
        for (int unsigned c = 0; c < OUTPUT_DIM; c++) w_mem[r][c] <= '0;
      for (int unsigned k = 0; k < INPUT_DIM; k++) begin
        x_reg[k] <= '0;
        eacc[k]  <= '0;
      end
      for (int unsigned c = 0; c < OUTPUT_DIM; c++) begin
        err_reg[c] <= '0;
        g_reg[c]   <= '0;
        acc[c]     <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          for (int unsigned r = 0; r < NROW; r++)
            for (int unsigned c = 0; c < OUTPUT_DIM; c++)
              if (w_wr_en && 32'(w_wr_row) == r && 32'(w_wr_col) == c) w_mem[r][c] <= w_wr_data;
          if (in_valid) begin
            row <= '0;
            if (!in_mode)
              for (int unsigned k = 0; k < INPUT_DIM; k++) x_reg[k] <= in_data[k*WIDTH +: WIDTH];
            else
              for (int unsigned c = 0; c < OUTPUT_DIM; c++) err_reg[c] <= in_error[c*WIDTH +: WIDTH];
          end
        end
        FWD: begin
          row <= row + 1'b1;
          for (int unsigned c = 0; c < OUTPUT_DIM; c++) begin
            if (row == '0)            acc[c] <= wrow[c];
            else if (row <= LAST_ROW) acc[c] <= ls[c];
            else                      out_data[c*WIDTH +: WIDTH] <= acc[c];
          end
          if (row == FIN_ROW) out_mode <= 1'b0;
        end
        BWD_SCALE: begin
          row <= '0;
          for (int unsigned c = 0; c < OUTPUT_DIM; c++) g_reg[c] <= lp[c];
        end
        BWD: begin
          row <= row + 1'b1;
          if (row <= LAST_ROW) begin
            for (int unsigned r = 0; r < NROW; r++)
              for (int unsigned c = 0; c < OUTPUT_DIM; c++)
                if (32'(row) == r) w_mem[r][c] <= ls[c];
            for (int unsigned k = 0; k < INPUT_DIM; k++)
              if (32'(row) == k + 1) eacc[k] <= esum;
          end else begin
            for (int unsigned k = 0; k < INPUT_DIM; k++) out_error[k*WIDTH +: WIDTH] <= eacc[k];
            out_mode <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
